// File: rtl/ctrl_pkg.sv
// Shared constants for the CPU control sequencer: opcodes, T-states and control-word layout.
package ctrl_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    localparam int BIT_HLT = 15;
    localparam int BIT_MI  = 14;
    localparam int BIT_RI  = 13;
    localparam int BIT_RO  = 12;
    localparam int BIT_IO  = 11;
    localparam int BIT_II  = 10;
    localparam int BIT_AI  = 9;
    localparam int BIT_AO  = 8;
    localparam int BIT_EO  = 7;
    localparam int BIT_SU  = 6;
    localparam int BIT_BI  = 5;
    localparam int BIT_OI  = 4;
    localparam int BIT_CP  = 3;
    localparam int BIT_EP  = 2;
    localparam int BIT_LP  = 1;
    localparam int BIT_FI  = 0;

    localparam logic [15:0] CW_T0   = 16'h4004;
    localparam logic [15:0] CW_T1   = 16'h1408;
    localparam logic [15:0] CW_HALT = 16'h8000;

    function automatic tstate_t next_tstate(input tstate_t s);
        return (s == T4) ? T0 : tstate_t'(s + 3'd1);
    endfunction

endpackage

// File: rtl/ctrl_microcode_rom.sv
// Combinational microcode: {opcode, step, cf, zf} -> {control word, last-step flag}.
module ctrl_microcode_rom
    import ctrl_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [2:0]  step,
    input  logic        cf,
    input  logic        zf,
    output logic [15:0] ctrl_word,
    output logic        last
);

    logic nop_class;
    assign nop_class = (opcode == OP_NOP) || ((opcode >= 4'h9) && (opcode <= 4'hD));

    // The T1 word ignores the opcode; only the early-end decision for NOP looks at it.
    always_comb begin
        ctrl_word = '0;
        last      = 1'b0;
        case (step)
            T0: ctrl_word = CW_T0;
            T1: begin
                ctrl_word = CW_T1;
                last      = nop_class;
            end
            T2: begin
                last = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_word[BIT_IO] = 1'b1;
                        ctrl_word[BIT_MI] = 1'b1;
                        last              = 1'b0;
                    end
                    OP_LDI: begin
                        ctrl_word[BIT_IO] = 1'b1;
                        ctrl_word[BIT_AI] = 1'b1;
                    end
                    OP_JMP: begin
                        ctrl_word[BIT_IO] = 1'b1;
                        ctrl_word[BIT_LP] = 1'b1;
                    end
                    OP_JC: begin
                        ctrl_word[BIT_IO] = cf;
                        ctrl_word[BIT_LP] = cf;
                    end
                    OP_JZ: begin
                        ctrl_word[BIT_IO] = zf;
                        ctrl_word[BIT_LP] = zf;
                    end
                    OP_OUT: begin
                        ctrl_word[BIT_AO] = 1'b1;
                        ctrl_word[BIT_OI] = 1'b1;
                    end
                    OP_HLT: ctrl_word[BIT_HLT] = 1'b1;
                    default: ctrl_word = '0;
                endcase
            end
            T3: begin
                last = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        ctrl_word[BIT_RO] = 1'b1;
                        ctrl_word[BIT_AI] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl_word[BIT_RO] = 1'b1;
                        ctrl_word[BIT_BI] = 1'b1;
                        last              = 1'b0;
                    end
                    OP_STA: begin
                        ctrl_word[BIT_AO] = 1'b1;
                        ctrl_word[BIT_RI] = 1'b1;
                    end
                    default: ctrl_word = '0;
                endcase
            end
            T4: begin
                last = 1'b1;
                if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    ctrl_word[BIT_EO] = 1'b1;
                    ctrl_word[BIT_AI] = 1'b1;
                    ctrl_word[BIT_FI] = 1'b1;
                    ctrl_word[BIT_SU] = (opcode == OP_SUB);
                end
            end
            default: last = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// T-state counter plus halt latch around the microcode ROM for the 8-bit CPU.
// Define CTRL_EARLY_END_EN to let each instruction return to T0 after its last used step.
module ctrl_sequencer
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        cf,
    input  logic        zf,
    output logic [15:0] ctrl_word,
    output logic [2:0]  step,
    output logic        halted
);

    tstate_t     step_q;
    logic        halted_q;
    logic [15:0] rom_word;
    logic        rom_last;
    logic        end_now;

    ctrl_microcode_rom u_rom (
        .opcode    (opcode),
        .step      (step_q),
        .cf        (cf),
        .zf        (zf),
        .ctrl_word (rom_word),
        .last      (rom_last)
    );

`ifdef CTRL_EARLY_END_EN
    assign end_now = rom_last;
`else
    logic unused_rom_last;
    assign unused_rom_last = rom_last;
    assign end_now         = 1'b0;
`endif

    // HLT freezes the counter at T2; only reset leaves the halted state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if ((step_q == T2) && (opcode == OP_HLT)) begin
                halted_q <= 1'b1;
            end else if (end_now) begin
                step_q <= T0;
            end else begin
                step_q <= next_tstate(step_q);
            end
        end
    end

    always_comb begin
        if (!rst_n) begin
            ctrl_word = '0;
        end else if (halted_q) begin
            ctrl_word = CW_HALT;
        end else begin
            ctrl_word = rom_word;
        end
    end

    assign step   = step_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer; expectations follow CTRL_EARLY_END_EN if defined.
module tb_ctrl_sequencer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode;
    logic        cf;
    logic        zf;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        halted;

    int checks_total  = 0;
    int checks_passed = 0;

    typedef struct {
        string       name;
        logic [3:0]  opcode;
        logic        cf;
        logic        zf;
        logic [2:0]  exp_step;
        logic [15:0] exp_cw;
    } vec_t;

    vec_t vecs[$];

    ctrl_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .cf        (cf),
        .zf        (zf),
        .ctrl_word (ctrl_word),
        .step      (step),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic add_vec(input string name, input logic [3:0] op, input logic c, input logic z,
                           input logic [2:0] s, input logic [15:0] cw);
        vec_t v;
        v.name     = name;
        v.opcode   = op;
        v.cf       = c;
        v.zf       = z;
        v.exp_step = s;
        v.exp_cw   = cw;
        vecs.push_back(v);
    endtask

    task automatic add_instr(input string name, input logic [3:0] op, input logic c, input logic z,
                             input logic [15:0] cw2, input logic [15:0] cw3, input logic [15:0] cw4);
        add_vec({name, "_t0"}, op, c, z, 3'd0, 16'h4004);
        add_vec({name, "_t1"}, op, c, z, 3'd1, 16'h1408);
        add_vec({name, "_t2"}, op, c, z, 3'd2, cw2);
        add_vec({name, "_t3"}, op, c, z, 3'd3, cw3);
        add_vec({name, "_t4"}, op, c, z, 3'd4, cw4);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic c, input logic z);
        opcode = op;
        cf     = c;
        zf     = z;
    endtask

    task automatic checkOutput(input string name, input logic [2:0] s, input logic [15:0] cw,
                               input logic h);
        checks_total++;
        if (step === s) checks_passed++;
        else $display("[TB] FAIL %s step: got %0d, expected %0d", name, step, s);
        checks_total++;
        if (ctrl_word === cw) checks_passed++;
        else $display("[TB] FAIL %s ctrl_word: got %h, expected %h", name, ctrl_word, cw);
        checks_total++;
        if (halted === h) checks_passed++;
        else $display("[TB] FAIL %s halted: got %b, expected %b", name, halted, h);
    endtask

    // Leaves rst_n released a few time units before a rising edge, so the next check sees T0.
    task automatic pulse_reset();
        @(negedge clk);
        applyStimulus(4'hF, 1'b1, 1'b1);
        rst_n = 1'b0;
        #2;
        checkOutput("reset", 3'd0, 16'h0000, 1'b0);
        #3;
        rst_n = 1'b1;
        #2;
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].opcode, vecs[i].cf, vecs[i].zf);
            #1;
            checkOutput(vecs[i].name, vecs[i].exp_step, vecs[i].exp_cw, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(4'h0, 1'b0, 1'b0);

`ifdef CTRL_EARLY_END_EN
        add_vec("ldi_t0", 4'h5, 0, 0, 3'd0, 16'h4004);
        add_vec("ldi_t1", 4'h5, 0, 0, 3'd1, 16'h1408);
        add_vec("ldi_t2", 4'h5, 0, 0, 3'd2, 16'h0A00);
        add_vec("nop_t0", 4'h0, 0, 0, 3'd0, 16'h4004);
        add_vec("nop_t1", 4'h0, 0, 0, 3'd1, 16'h1408);
        add_vec("sta_t0", 4'h4, 0, 0, 3'd0, 16'h4004);
        add_vec("sta_t1", 4'h4, 0, 0, 3'd1, 16'h1408);
        add_vec("sta_t2", 4'h4, 0, 0, 3'd2, 16'h4800);
        add_vec("sta_t3", 4'h4, 0, 0, 3'd3, 16'h2100);
        add_vec("jc1_t0", 4'h7, 1, 0, 3'd0, 16'h4004);
        add_vec("jc1_t1", 4'h7, 1, 0, 3'd1, 16'h1408);
        add_vec("jc1_t2", 4'h7, 1, 0, 3'd2, 16'h0802);
        add_vec("jc0_t0", 4'h7, 0, 1, 3'd0, 16'h4004);
        add_vec("jc0_t1", 4'h7, 0, 1, 3'd1, 16'h1408);
        add_vec("jc0_t2", 4'h7, 0, 1, 3'd2, 16'h0000);
        add_vec("lda_t0", 4'h1, 0, 0, 3'd0, 16'h4004);
        add_vec("lda_t1", 4'h1, 0, 0, 3'd1, 16'h1408);
        add_vec("lda_t2", 4'h1, 0, 0, 3'd2, 16'h4800);
        add_vec("lda_t3", 4'h1, 0, 0, 3'd3, 16'h1200);
        add_instr("sub", 4'h3, 0, 0, 16'h4800, 16'h1020, 16'h02C1);
        add_vec("opb_t0", 4'hB, 0, 0, 3'd0, 16'h4004);
        add_vec("opb_t1", 4'hB, 0, 0, 3'd1, 16'h1408);
        add_vec("end_t0", 4'h0, 0, 0, 3'd0, 16'h4004);
`else
        add_instr("nop",  4'h0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        add_instr("add",  4'h2, 0, 0, 16'h4800, 16'h1020, 16'h0281);
        add_instr("sub",  4'h3, 0, 0, 16'h4800, 16'h1020, 16'h02C1);
        add_instr("lda",  4'h1, 0, 0, 16'h4800, 16'h1200, 16'h0000);
        add_instr("sta",  4'h4, 0, 0, 16'h4800, 16'h2100, 16'h0000);
        add_instr("ldi",  4'h5, 0, 0, 16'h0A00, 16'h0000, 16'h0000);
        add_instr("jmp",  4'h6, 0, 0, 16'h0802, 16'h0000, 16'h0000);
        add_instr("jc1",  4'h7, 1, 0, 16'h0802, 16'h0000, 16'h0000);
        add_instr("jc0",  4'h7, 0, 1, 16'h0000, 16'h0000, 16'h0000);
        add_instr("jz1",  4'h8, 0, 1, 16'h0802, 16'h0000, 16'h0000);
        add_instr("jz0",  4'h8, 1, 0, 16'h0000, 16'h0000, 16'h0000);
        add_instr("out",  4'hE, 0, 0, 16'h0110, 16'h0000, 16'h0000);
        add_instr("op9",  4'h9, 1, 1, 16'h0000, 16'h0000, 16'h0000);
        add_instr("opd",  4'hD, 1, 1, 16'h0000, 16'h0000, 16'h0000);
        add_vec("jclate_t0", 4'h7, 0, 0, 3'd0, 16'h4004);
        add_vec("jclate_t1", 4'h7, 0, 0, 3'd1, 16'h1408);
        add_vec("jclate_t2", 4'h7, 0, 0, 3'd2, 16'h0000);
        add_vec("jclate_t3", 4'h7, 1, 1, 3'd3, 16'h0000);
        add_vec("jclate_t4", 4'h7, 1, 1, 3'd4, 16'h0000);
        add_vec("wrap_t0",   4'h0, 0, 0, 3'd0, 16'h4004);
`endif

        $display("[TB] running %0d table vectors", vecs.size());
        pulse_reset();
        run_table();

        // HLT: the T2 edge sets halted and the step counter freezes at 2.
        pulse_reset();
        applyStimulus(4'hF, 1'b0, 1'b0);
        #1;
        checkOutput("hlt_t0", 3'd0, 16'h4004, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("hlt_t1", 3'd1, 16'h1408, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("hlt_t2", 3'd2, 16'h8000, 1'b0);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i > 0) applyStimulus(4'h2, 1'b1, 1'b1);
            #1;
            checkOutput("hlt_hold", 3'd2, 16'h8000, 1'b1);
        end

        // Reset pulsed in the middle of LDA T3.
        pulse_reset();
        applyStimulus(4'h1, 1'b0, 1'b0);
        #1;
        checkOutput("ldarst_t0", 3'd0, 16'h4004, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("ldarst_t1", 3'd1, 16'h1408, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("ldarst_t2", 3'd2, 16'h4800, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("ldarst_t3", 3'd3, 16'h1200, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ldarst_low", 3'd0, 16'h0000, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("ldarst_first", 3'd0, 16'h4004, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("ldarst_next", 3'd1, 16'h1408, 1'b0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
